// File: rtl/mem_wb_stage_if.sv
// EX/MEM -> MEM/WB boundary bundle: MEM-stage control/data in, registered WB results
// and the MEM-stage forwarding value out.
interface mem_wb_stage_if;
  logic        regwriteM;
  logic [1:0]  memtoregM;
  logic        memwriteM;
  logic        MemReadM;
  logic [2:0]  mem_opM;
  logic [31:0] ALU_outM;
  logic [31:0] WriteDataM;
  logic [4:0]  WriteRegM;
  logic [31:0] PC_8M;

  logic [31:0] fwd_dataM;
  logic        regwriteW;
  logic [1:0]  memtoregW;
  logic [31:0] ALU_outW;
  logic [31:0] ReadDataW;
  logic [4:0]  WriteRegW;
  logic [31:0] PC_8W;
  logic [1:0]  addr_excW;

  modport master (
    output regwriteM, memtoregM, memwriteM, MemReadM, mem_opM,
           ALU_outM, WriteDataM, WriteRegM, PC_8M,
    input  fwd_dataM, regwriteW, memtoregW, ALU_outW, ReadDataW,
           WriteRegW, PC_8W, addr_excW
  );

  modport slave (
    input  regwriteM, memtoregM, memwriteM, MemReadM, mem_opM,
           ALU_outM, WriteDataM, WriteRegM, PC_8M,
    output fwd_dataM, regwriteW, memtoregW, ALU_outW, ReadDataW,
           WriteRegW, PC_8W, addr_excW
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage: data memory (byte/half/word stores, extending loads), address-exception
// detection, and the MEM/WB pipeline register.
module mem_wb_stage #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input logic           clk,
  input logic           reset,
  mem_wb_stage_if.slave bus
);

  logic [31:0] r_mem [DEPTH];

  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic          w_half, w_byte, w_word;
  logic          w_misalign, w_oor, w_exc, w_store, w_load;
  logic [31:0]   w_rword, w_wword, w_ldata;
  logic [15:0]   w_rhalf;
  logic [7:0]    w_rbyte;
  logic [1:0]    w_exc_code;

  assign w_idx  = bus.ALU_outM[AW+1:2];
  assign w_lane = bus.ALU_outM[1:0];

  // Reserved size codes 101-111 fall back to word access.
  assign w_half = (bus.mem_opM == 3'b001) || (bus.mem_opM == 3'b010);
  assign w_byte = (bus.mem_opM == 3'b011) || (bus.mem_opM == 3'b100);
  assign w_word = !w_half && !w_byte;

  assign w_misalign = (w_word && (w_lane != 2'b00)) || (w_half && w_lane[0]);
  assign w_oor      = bus.ALU_outM >= 32'(DEPTH * 4);
  assign w_exc      = (bus.MemReadM || bus.memwriteM) && (w_misalign || w_oor);
  assign w_store    = bus.memwriteM && !w_exc;
  // A simultaneous read+write is treated purely as a store.
  assign w_load     = bus.MemReadM && !bus.memwriteM && !w_exc;
  assign w_exc_code = !w_exc ? 2'b00 : (bus.memwriteM ? 2'b10 : 2'b01);

  assign w_rword = r_mem[w_idx];
  assign w_rhalf = w_lane[1] ? w_rword[31:16] : w_rword[15:0];
  assign w_rbyte = w_rword[{w_lane, 3'b000} +: 8];

  always_comb begin
    w_ldata = w_rword;
    case (bus.mem_opM)
      3'b001:  w_ldata = {16'h0000, w_rhalf};
      3'b010:  w_ldata = {{16{w_rhalf[15]}}, w_rhalf};
      3'b011:  w_ldata = {24'h000000, w_rbyte};
      3'b100:  w_ldata = {{24{w_rbyte[7]}}, w_rbyte};
      default: w_ldata = w_rword;
    endcase
  end

  // Read-modify-write merge so untouched lanes keep their contents.
  always_comb begin
    w_wword = w_rword;
    if (w_byte)      w_wword[{w_lane, 3'b000} +: 8]       = bus.WriteDataM[7:0];
    else if (w_half) w_wword[{w_lane[1], 4'b0000} +: 16] = bus.WriteDataM[15:0];
    else             w_wword = bus.WriteDataM;
  end

  assign bus.fwd_dataM = (bus.memtoregM == 2'b10) ? bus.PC_8M : bus.ALU_outM;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      bus.regwriteW <= 1'b0;
      bus.memtoregW <= '0;
      bus.ALU_outW  <= '0;
      bus.ReadDataW <= '0;
      bus.WriteRegW <= '0;
      bus.PC_8W     <= '0;
      bus.addr_excW <= '0;
    end else begin
      if (w_store) r_mem[w_idx] <= w_wword;
      bus.regwriteW <= bus.regwriteM && !w_exc;
      bus.memtoregW <= bus.memtoregM;
      bus.ALU_outW  <= bus.ALU_outM;
      bus.ReadDataW <= w_load ? w_ldata : 32'h0;
      bus.WriteRegW <= bus.WriteRegM;
      bus.PC_8W     <= bus.PC_8M;
      bus.addr_excW <= w_exc_code;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: hand-computed loads/stores, exceptions, forwarding, reset.
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   ncmp = 0;
  int   nfail = 0;

  mem_wb_stage_if bus ();

  mem_wb_stage #(.DEPTH(1024), .AW(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic rw, input logic [1:0] mtr, input logic mw, input logic mr,
                     input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [4:0] wreg, input logic [31:0] pc8);
    bus.regwriteM  = rw;
    bus.memtoregM  = mtr;
    bus.memwriteM  = mw;
    bus.MemReadM   = mr;
    bus.mem_opM    = op;
    bus.ALU_outM   = addr;
    bus.WriteDataM = wd;
    bus.WriteRegM  = wreg;
    bus.PC_8M      = pc8;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // load: regwrite=1, memtoreg=01
  task automatic ld(input logic [2:0] op, input logic [31:0] addr);
    drv(1'b1, 2'b01, 1'b0, 1'b1, op, addr, 32'h0, 5'd8, 32'h0);
    tick();
  endtask

  task automatic st(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    drv(1'b0, 2'b00, 1'b1, 1'b0, op, addr, wd, 5'd0, 32'h0);
    tick();
  endtask

  initial begin
    // Reset held 2 cycles while a store with nonzero fields is presented.
    drv(1'b1, 2'b10, 1'b1, 1'b0, 3'b000, 32'h10, 32'hFFFFFFFF, 5'd7, 32'h1234);
    tick();
    tick();
    chk("rst_regwriteW", 32'(bus.regwriteW), 32'h0);
    chk("rst_memtoregW", 32'(bus.memtoregW), 32'h0);
    chk("rst_ALU_outW",  bus.ALU_outW, 32'h0);
    chk("rst_ReadDataW", bus.ReadDataW, 32'h0);
    chk("rst_WriteRegW", 32'(bus.WriteRegW), 32'h0);
    chk("rst_PC_8W",     bus.PC_8W, 32'h0);
    chk("rst_addr_excW", 32'(bus.addr_excW), 32'h0);
    reset = 1'b1;

    ld(3'b000, 32'h0);
    chk("lw0_data", bus.ReadDataW, 32'h0);
    chk("lw0_rw",   32'(bus.regwriteW), 32'h1);
    chk("lw0_wreg", 32'(bus.WriteRegW), 32'd8);
    chk("rst_store_dropped_probe", 32'(bus.addr_excW), 32'h0);
    ld(3'b000, 32'h10);
    chk("rst_store_dropped", bus.ReadDataW, 32'h0);

    st(3'b000, 32'h10, 32'h8899AABB);
    chk("sw_data0", bus.ReadDataW, 32'h0);
    chk("sw_exc",   32'(bus.addr_excW), 32'h0);
    ld(3'b000, 32'h10);
    chk("lw10",     bus.ReadDataW, 32'h8899AABB);
    chk("lw10_rw",  32'(bus.regwriteW), 32'h1);
    chk("lw10_exc", 32'(bus.addr_excW), 32'h0);

    st(3'b011, 32'h13, 32'h123456F0);
    ld(3'b100, 32'h13);
    chk("lb13",  bus.ReadDataW, 32'hFFFFFFF0);
    ld(3'b011, 32'h13);
    chk("lbu13", bus.ReadDataW, 32'h000000F0);
    ld(3'b000, 32'h10);
    chk("lw10_after_sb", bus.ReadDataW, 32'hF099AABB);
    ld(3'b011, 32'h10);
    chk("lbu10", bus.ReadDataW, 32'h000000BB);

    st(3'b001, 32'h12, 32'hFFFF8001);
    ld(3'b010, 32'h12);
    chk("lh12",  bus.ReadDataW, 32'hFFFF8001);
    ld(3'b001, 32'h10);
    chk("lhu10", bus.ReadDataW, 32'h0000AABB);
    ld(3'b101, 32'h10);
    chk("lw_op5", bus.ReadDataW, 32'h8001AABB);

    // Address exceptions
    ld(3'b000, 32'h11);
    chk("lw11_exc",  32'(bus.addr_excW), 32'h1);
    chk("lw11_rw",   32'(bus.regwriteW), 32'h0);
    chk("lw11_data", bus.ReadDataW, 32'h0);
    ld(3'b001, 32'h11);
    chk("lhu11_exc", 32'(bus.addr_excW), 32'h1);
    drv(1'b1, 2'b00, 1'b1, 1'b0, 3'b000, 32'h1002, 32'hDEADBEEF, 5'd3, 32'h0);
    tick();
    chk("sw1002_exc", 32'(bus.addr_excW), 32'h2);
    chk("sw1002_rw",  32'(bus.regwriteW), 32'h0);
    st(3'b000, 32'h12, 32'hDEADBEEF);
    chk("sw12_exc", 32'(bus.addr_excW), 32'h2);
    st(3'b001, 32'h11, 32'hDEADBEEF);
    chk("sh11_exc", 32'(bus.addr_excW), 32'h2);
    ld(3'b000, 32'h10);
    chk("lw10_unchanged", bus.ReadDataW, 32'h8001AABB);
    ld(3'b000, 32'h0);
    chk("lw0_wrap_unchanged", bus.ReadDataW, 32'h0);
    ld(3'b000, 32'h1000);
    chk("lw1000_exc", 32'(bus.addr_excW), 32'h1);

    // Last valid word
    st(3'b000, 32'hFFC, 32'hCAFEF00D);
    chk("swFFC_exc", 32'(bus.addr_excW), 32'h0);
    ld(3'b000, 32'hFFC);
    chk("lwFFC", bus.ReadDataW, 32'hCAFEF00D);
    ld(3'b011, 32'hFFF);
    chk("lbuFFF", bus.ReadDataW, 32'h000000CA);

    // Read+write together acts as a store
    drv(1'b1, 2'b01, 1'b1, 1'b1, 3'b000, 32'h30, 32'h00000055, 5'd9, 32'h0);
    tick();
    chk("rw_data0", bus.ReadDataW, 32'h0);
    chk("rw_exc",   32'(bus.addr_excW), 32'h0);
    ld(3'b000, 32'h30);
    chk("lw30", bus.ReadDataW, 32'h00000055);
    drv(1'b1, 2'b01, 1'b1, 1'b1, 3'b000, 32'h31, 32'h0, 5'd9, 32'h0);
    tick();
    chk("rw_misal_exc", 32'(bus.addr_excW), 32'h2);

    // Forwarding and pass-through
    drv(1'b1, 2'b10, 1'b0, 1'b0, 3'b000, 32'h44, 32'h0, 5'd31, 32'h00003008);
    #1;
    chk("fwd_pc8", bus.fwd_dataM, 32'h00003008);
    tick();
    chk("pc8W",      bus.PC_8W, 32'h00003008);
    chk("mtrW",      32'(bus.memtoregW), 32'h2);
    chk("aluW",      bus.ALU_outW, 32'h44);
    chk("wregW",     32'(bus.WriteRegW), 32'd31);
    chk("nomem_rd0", bus.ReadDataW, 32'h0);
    drv(1'b1, 2'b11, 1'b0, 1'b0, 3'b000, 32'h77, 32'h0, 5'd0, 32'h00003008);
    #1;
    chk("fwd_alu_11", bus.fwd_dataM, 32'h77);
    tick();
    chk("rw_reg0", 32'(bus.regwriteW), 32'h1);

    // Reset asserted during a store drops it and clears memory
    reset = 1'b0;
    st(3'b000, 32'h20, 32'h00001234);
    reset = 1'b1;
    ld(3'b000, 32'h20);
    chk("lw20_after_rst", bus.ReadDataW, 32'h0);
    ld(3'b000, 32'h10);
    chk("lw10_after_rst", bus.ReadDataW, 32'h0);
    ld(3'b000, 32'hFFC);
    chk("lwFFC_after_rst", bus.ReadDataW, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
